// File: rtl/pulse_drv_stretch.sv
// Converts single-cycle command pulses into timed actuator drives:
// ON_CYCLES high then OFF_CYCLES low, with a saturating queue of pending requests.
module pulse_drv_stretch #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int QCNT_W     = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_pulse,
  output logic              drive,
  output logic              busy,
  output logic [QCNT_W-1:0] pending,
  output logic              ovf
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [QCNT_W-1:0] Q_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic                r_drive;
  logic [QCNT_W-1:0]   r_pending;
  logic                r_ovf;

  logic w_on_last;
  logic w_off_last;
  logic w_pend_nz;
  logic w_direct;
  logic w_enq;
  logic w_deq;

  always_comb begin
    w_on_last  = (r_state == S_ON)  && (r_timer == ON_LAST);
    w_off_last = (r_state == S_OFF) && (r_timer == OFF_LAST);
    w_pend_nz  = (r_pending != '0);
    // A request bypasses the queue when the machine can start it right away.
    w_direct   = req_pulse && ((r_state == S_IDLE) || (w_off_last && !w_pend_nz));
    w_enq      = req_pulse && !w_direct;
    w_deq      = w_off_last && w_pend_nz;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_drive   <= 1'b0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (req_pulse) begin
            r_state <= S_ON;
            r_drive <= 1'b1;
          end
        end
        S_ON: begin
          if (w_on_last) begin
            r_state <= S_OFF;
            r_timer <= '0;
            r_drive <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_OFF: begin
          if (w_off_last) begin
            r_timer <= '0;
            if (w_pend_nz || req_pulse) begin
              r_state <= S_ON;
              r_drive <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_drive <= 1'b0;
        end
      endcase

      if (w_enq && !w_deq) begin
        if (r_pending != Q_MAX) r_pending <= r_pending + QCNT_W'(1);
      end else if (w_deq && !w_enq) begin
        r_pending <= r_pending - QCNT_W'(1);
      end

      r_ovf <= w_enq && !w_deq && (r_pending == Q_MAX);
    end
  end

  assign drive   = r_drive;
  assign pending = r_pending;
  assign ovf     = r_ovf;
  assign busy    = (r_state != S_IDLE) || w_pend_nz;

endmodule
